// File: rtl/fifo_burst_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_pkg
// Shared definitions for the read-side burst consumer of the asynchronous FIFO.
// Contents:
//   state_e          - burst reader FSM states (IDLE, READ, GAP)
//   DEF_*            - default word width, burst length and inter-read delay
//   min1_clog2()     - $clog2 that never returns less than 1 (counter widths)
// -----------------------------------------------------------------------------
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_LEN  = 15;
    localparam int DEF_READ_DELAY = 5;

    // Width needed to hold values 0..v-1, but at least one bit so a counter
    // always exists even when it is never used (e.g. READ_DELAY = 0).
    function automatic int min1_clog2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_out_skid_buf.sv
// -----------------------------------------------------------------------------
// out_skid_buf
// Two-entry valid/ready output buffer. Words pushed in are presented in order
// at the head; the head is popped when the consumer accepts it. A push and a
// pop in the same cycle leave the occupancy unchanged.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   push_i         - write push_data_i into the tail this cycle
//   push_data_i    - word to store
//   pop_i          - consumer ready; only acts when the buffer holds a word
//   data_o         - head word (0 after reset)
//   valid_o        - buffer holds at least one word
//   count_o        - occupancy, 0..2
// -----------------------------------------------------------------------------
module out_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        // A full buffer can still take a word when the head leaves this cycle.
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Read-domain consumer of the asynchronous FIFO. On enable it issues a burst
// of BURST_LEN reads, separated by READ_DELAY idle cycles, and streams the
// returned words out on a valid/ready interface through a 2-entry buffer.
// A read is only issued when the FIFO is not empty and the returned word is
// guaranteed a buffer slot.
// Ports:
//   rclk, rrst_n  - read clock, asynchronous active-low reset
//   enable        - start a burst (sampled only while idle)
//   rempty        - FIFO empty flag
//   rinc          - FIFO read increment, one pulse per word
//   rdata         - FIFO read data, valid the cycle after rinc
//   m_data        - output stream data
//   m_valid       - output stream valid
//   m_ready       - output stream accept
//   rd_count      - reads issued in the current/last burst
//   burst_done    - one-cycle pulse after the last read of a burst
// -----------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int READ_DELAY = DEF_READ_DELAY
) (
    input  logic                           rclk,
    input  logic                           rrst_n,
    input  logic                           enable,
    input  logic                           rempty,
    output logic                           rinc,
    input  logic [DATA_WIDTH-1:0]          rdata,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [$clog2(BURST_LEN+1)-1:0] rd_count,
    output logic                           burst_done
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int GAP_W = min1_clog2(READ_DELAY + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((READ_DELAY > 0) ? READ_DELAY - 1 : 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               inflight_q, inflight_d;
    logic               done_q, done_d;

    logic [1:0]         buf_count;
    logic               pop;
    logic [2:0]         pending;
    logic               room;
    logic               issue;

    out_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk_i       (rclk),
        .rst_ni      (rrst_n),
        .push_i      (inflight_q),
        .push_data_i (rdata),
        .pop_i       (m_ready),
        .data_o      (m_data),
        .valid_o     (m_valid),
        .count_o     (buf_count)
    );

    // Words already owed to the buffer after this cycle's pop. Counting the
    // pop lets back-to-back reads sustain a continuous stream while the
    // consumer keeps up, without ever exceeding two held words.
    assign pop     = m_valid && m_ready;
    assign pending = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign room    = (pending < 3'd2);

    // State register
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        done_d     = 1'b0;
        inflight_d = issue;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                if (issue) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (READ_DELAY > 0) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                end
            end
            ST_GAP: begin
                // GAP lasts READ_DELAY cycles, giving READ_DELAY+1 between reads.
                if (gap_q == GAP_LAST) begin
                    state_d = ST_READ;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        issue      = (state_q == ST_READ) && !rempty && room;
        rinc       = issue;
        rd_count   = cnt_q;
        burst_done = done_q;
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

    localparam int DW   = 8;
    localparam int BL_A = 15;
    localparam int RD_A = 5;
    localparam int BL_B = 4;
    localparam int RD_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rrst_n = 1'b0;
    logic [1:0]    enable_r = 2'b00;
    logic [1:0]    m_ready_r = 2'b00;
    logic [1:0]    rempty_r = 2'b11;
    logic [DW-1:0] rdata_r [2] = '{8'h00, 8'h00};
    logic [1:0]    rinc_w, m_valid_w, burst_done_w;
    logic [DW-1:0] m_data_w [2];
    logic [3:0]    rd_cnt_a;
    logic [2:0]    rd_cnt_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL_A), .READ_DELAY(RD_A)) dut_a (
        .rclk(clk), .rrst_n(rrst_n), .enable(enable_r[0]), .rempty(rempty_r[0]),
        .rinc(rinc_w[0]), .rdata(rdata_r[0]), .m_data(m_data_w[0]), .m_valid(m_valid_w[0]),
        .m_ready(m_ready_r[0]), .rd_count(rd_cnt_a), .burst_done(burst_done_w[0])
    );

    fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL_B), .READ_DELAY(RD_B)) dut_b (
        .rclk(clk), .rrst_n(rrst_n), .enable(enable_r[1]), .rempty(rempty_r[1]),
        .rinc(rinc_w[1]), .rdata(rdata_r[1]), .m_data(m_data_w[1]), .m_valid(m_valid_w[1]),
        .m_ready(m_ready_r[1]), .rd_count(rd_cnt_b), .burst_done(burst_done_w[1])
    );

    // FIFO emulation: writes land one cycle after being requested; rdata is
    // registered and updated on the edge that ends a rinc cycle.
    int fifo_q  [2][$];
    int wr_pend [2][$];

    always @(posedge clk) begin
        for (int id = 0; id < 2; id++) begin
            if (rinc_w[id] && fifo_q[id].size() > 0)
                rdata_r[id] <= DW'(fifo_q[id].pop_front());
            while (wr_pend[id].size() > 0)
                fifo_q[id].push_back(wr_pend[id].pop_front());
            rempty_r[id] <= (fifo_q[id].size() == 0);
        end
    end

    // Behavioural model: words not yet read, words read but not yet delivered
    // (with the cycle they were read), and the burst bookkeeping.
    int exp_words [2][$];
    int oq_d      [2][$];
    int oq_c      [2][$];
    bit in_burst  [2] = '{1'b0, 1'b0};
    int cnt       [2] = '{0, 0};
    int earliest  [2] = '{0, 0};
    bit done_pend [2] = '{1'b0, 1'b0};

    // Observation logs for the directed checks.
    int rinc_log [2][$];
    int del_q    [2][$];
    int del_cyc  [2][$];
    int done_cnt [2] = '{0, 0};

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int id);
        string pfx;
        int    bl, rd, act_cnt, w;
        bit    exp_valid, pop, exp_rinc, was_idle;
        pfx     = (id == 0) ? "A" : "B";
        bl      = (id == 0) ? BL_A : BL_B;
        rd      = (id == 0) ? RD_A : RD_B;
        act_cnt = (id == 0) ? int'(rd_cnt_a) : int'(rd_cnt_b);
        if (!rrst_n) begin
            chk({pfx, ".rst.rinc"},       rinc_w[id],       0);
            chk({pfx, ".rst.m_valid"},    m_valid_w[id],    0);
            chk({pfx, ".rst.m_data"},     m_data_w[id],     0);
            chk({pfx, ".rst.rd_count"},   act_cnt,          0);
            chk({pfx, ".rst.burst_done"}, burst_done_w[id], 0);
            oq_d[id].delete();
            oq_c[id].delete();
            in_burst[id]  = 1'b0;
            cnt[id]       = 0;
            done_pend[id] = 1'b0;
        end else begin
            exp_valid = (oq_c[id].size() > 0) && ((cyc - oq_c[id][0]) >= 2);
            pop       = exp_valid && m_ready_r[id];
            exp_rinc  = in_burst[id] && (cyc >= earliest[id]) && !rempty_r[id] &&
                        ((oq_c[id].size() - (pop ? 1 : 0)) < 2);
            chk({pfx, ".rinc"},       rinc_w[id],       int'(exp_rinc));
            chk({pfx, ".m_valid"},    m_valid_w[id],    int'(exp_valid));
            chk({pfx, ".rd_count"},   act_cnt,          cnt[id]);
            chk({pfx, ".burst_done"}, burst_done_w[id], int'(done_pend[id]));
            if (exp_valid) chk({pfx, ".m_data"}, m_data_w[id], oq_d[id][0]);
            if (m_valid_w[id] && m_ready_r[id]) begin
                del_q[id].push_back(int'(m_data_w[id]));
                del_cyc[id].push_back(cyc);
            end
            if (rinc_w[id]) rinc_log[id].push_back(cyc);
            if (burst_done_w[id]) done_cnt[id]++;
            // advance model to the end of this cycle
            was_idle = !in_burst[id];
            if (pop) begin
                void'(oq_d[id].pop_front());
                void'(oq_c[id].pop_front());
            end
            done_pend[id] = 1'b0;
            if (exp_rinc) begin
                w = (exp_words[id].size() > 0) ? exp_words[id].pop_front() : -1;
                oq_d[id].push_back(w);
                oq_c[id].push_back(cyc);
                cnt[id]++;
                earliest[id] = cyc + rd + 1;
                if (cnt[id] == bl) begin
                    in_burst[id]  = 1'b0;
                    done_pend[id] = 1'b1;
                end
            end
            if (was_idle && enable_r[id]) begin
                in_burst[id] = 1'b1;
                cnt[id]      = 0;
                earliest[id] = cyc + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int id, input int w);
        wr_pend[id].push_back(w);
        exp_words[id].push_back(w);
    endtask

    task automatic clear_logs(input int id);
        rinc_log[id].delete();
        del_q[id].delete();
        del_cyc[id].delete();
        done_cnt[id] = 0;
    endtask

    task automatic start_burst(input int id, output int en_cyc);
        enable_r[id] = 1'b1;
        en_cyc = cyc;
        tick();
        enable_r[id] = 1'b0;
    endtask

    task automatic wait_idle(input int id, input int budget, input string name);
        int n;
        n = 0;
        while (!(!in_burst[id] && oq_c[id].size() == 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(!in_burst[id] && oq_c[id].size() == 0), 1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int en, w, n, changes, d;
        int first;

        // reset and idle behaviour
        rrst_n = 1'b0;
        repeat (3) tick();
        chk("rst_m_valid", m_valid_w[0], 0);
        chk("rst_m_data",  m_data_w[0],  0);
        chk("rst_rd_count", rd_cnt_a,    0);
        rrst_n = 1'b1;
        tick();
        for (int i = 1; i <= 15; i++) write_word(0, i);
        repeat (10) tick();
        chk("idle_no_rinc", rinc_log[0].size(), 0);

        // nominal burst, READ_DELAY=5
        m_ready_r[0] = 1'b1;
        clear_logs(0);
        start_burst(0, en);
        wait_idle(0, 300, "nom_complete");
        chk("nom_rinc_count", rinc_log[0].size(), 15);
        if (rinc_log[0].size() > 0) chk("nom_first_rinc", rinc_log[0][0] - en, 1);
        for (int i = 1; i < rinc_log[0].size(); i++)
            chk("nom_rinc_spacing", rinc_log[0][i] - rinc_log[0][i-1], 6);
        if (del_cyc[0].size() > 0 && rinc_log[0].size() > 0)
            chk("nom_latency", del_cyc[0][0] - rinc_log[0][0], 2);
        chk("nom_word_count", del_q[0].size(), 15);
        for (int i = 0; i < del_q[0].size(); i++) chk("nom_data", del_q[0][i], i + 1);
        chk("nom_burst_done", done_cnt[0], 1);
        chk("nom_rd_count_hold", rd_cnt_a, 15);

        // empty stall
        clear_logs(0);
        for (int i = 1; i <= 4; i++) write_word(0, i);
        start_burst(0, en);
        repeat (40) tick();
        chk("stall_reads", rinc_log[0].size(), 4);
        chk("stall_rempty", rempty_r[0], 1);
        w = cyc;
        write_word(0, 5);
        repeat (3) tick();
        chk("stall_resume_count", rinc_log[0].size(), 5);
        if (rinc_log[0].size() >= 5) begin
            d = rinc_log[0][4] - (w + 1);
            chk("stall_resume_within1", int'(d >= 0 && d <= 1), 1);
        end
        for (int i = 6; i <= 15; i++) write_word(0, i);
        wait_idle(0, 300, "stall_complete");
        chk("stall_word_count", del_q[0].size(), 15);
        for (int i = 0; i < del_q[0].size(); i++) chk("stall_data", del_q[0][i], i + 1);
        chk("stall_burst_done", done_cnt[0], 1);

        // back-pressure
        clear_logs(0);
        m_ready_r[0] = 1'b0;
        for (int i = 0; i < 15; i++) write_word(0, 8'h21 + i);
        start_burst(0, en);
        changes = 0;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_valid_w[0]) begin
                if (first < 0) first = int'(m_data_w[0]);
                else if (int'(m_data_w[0]) != first) changes++;
            end
        end
        chk("bp_rinc_count", rinc_log[0].size(), 2);
        chk("bp_m_valid", m_valid_w[0], 1);
        chk("bp_m_data", m_data_w[0], 8'h21);
        chk("bp_data_changes", changes, 0);
        m_ready_r[0] = 1'b1;
        wait_idle(0, 400, "bp_complete");
        chk("bp_word_count", del_q[0].size(), 15);
        for (int i = 0; i < del_q[0].size(); i++) chk("bp_data", del_q[0][i], 8'h21 + i);
        chk("bp_burst_done", done_cnt[0], 1);

        // READ_DELAY=0, BURST_LEN=4
        clear_logs(1);
        m_ready_r[1] = 1'b1;
        for (int i = 0; i < 4; i++) write_word(1, 8'h11 + i);
        tick();
        start_burst(1, en);
        wait_idle(1, 100, "b2b_complete");
        chk("b2b_rinc_count", rinc_log[1].size(), 4);
        if (rinc_log[1].size() > 0) chk("b2b_first_rinc", rinc_log[1][0] - en, 1);
        for (int i = 1; i < rinc_log[1].size(); i++)
            chk("b2b_rinc_consecutive", rinc_log[1][i] - rinc_log[1][i-1], 1);
        chk("b2b_word_count", del_q[1].size(), 4);
        for (int i = 0; i < del_q[1].size(); i++) chk("b2b_data", del_q[1][i], 8'h11 + i);
        for (int i = 1; i < del_cyc[1].size(); i++)
            chk("b2b_stream_gapless", del_cyc[1][i] - del_cyc[1][i-1], 1);
        chk("b2b_burst_done", done_cnt[1], 1);
        chk("b2b_rd_count", rd_cnt_b, 4);

        // reset mid-burst after 7 reads
        clear_logs(0);
        for (int i = 0; i < 15; i++) write_word(0, 8'h41 + i);
        start_burst(0, en);
        n = 0;
        while (rinc_log[0].size() < 7 && n < 100) begin
            tick();
            n++;
        end
        chk("mid_reached_7", rinc_log[0].size(), 7);
        chk("mid_rd_count_7", rd_cnt_a, 7);
        rrst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid_w[0], 0);
        chk("mid_rst_m_data", m_data_w[0], 0);
        chk("mid_rst_rd_count", rd_cnt_a, 0);
        tick();
        tick();
        rrst_n = 1'b1;
        tick();
        clear_logs(0);
        for (int i = 0; i < 7; i++) write_word(0, 8'h50 + i);
        start_burst(0, en);
        chk("restart_rd_count0", rd_cnt_a, 0);
        tick();
        chk("restart_rd_count1", rd_cnt_a, 1);
        wait_idle(0, 300, "restart_complete");
        chk("restart_word_count", del_q[0].size(), 15);
        for (int i = 0; i < del_q[0].size(); i++) chk("restart_data", del_q[0][i], 8'h48 + i);
        chk("restart_burst_done", done_cnt[0], 1);
        chk("restart_rd_count", rd_cnt_a, 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side consumer of the asynchronous FIFO, in the read clock domain. Drains the FIFO in bursts of BURST_LEN words, spacing individual reads by READ_DELAY idle cycles. Captures the FIFO's registered read data into a 2-entry output buffer and presents it on a valid/ready stream to the downstream datapath. Asserts `rinc` only when a word can be accepted without loss.

## Interface
- DATA_WIDTH, 8, FIFO word width
- BURST_LEN, 15, reads per burst (≥1)
- READ_DELAY, 5, idle cycles between consecutive reads in a burst (0 = back-to-back)
- rclk  in  1  read-domain clock; all logic on rising edge
- rrst_n  in  1  reset; asynchronous assert, active-low (single clock, async active-low reset is fixed)
- enable  in  1  start request; sampled only in IDLE
- rempty  in  1  FIFO empty flag (read domain)
- rinc  out  1  FIFO read increment, one pulse per word
- rdata  in  DATA_WIDTH  FIFO read data, valid the cycle after `rinc`
- m_data  out  DATA_WIDTH  output stream data
- m_valid  out  1  output stream valid
- m_ready  in  1  downstream accept
- rd_count  out  $clog2(BURST_LEN+1)  reads issued in current burst
- burst_done  out  1  one-cycle pulse after last read of a burst is issued

## Operation
- FSM states: IDLE, READ, GAP.
- IDLE: `enable`=1 → READ, `rd_count` cleared.
- READ: issue `rinc`=1 when `!rempty` and (buffer occupancy + in-flight read) < 2; else stall in READ with `rinc`=0. On issue, `rd_count`+1. If `rd_count` becomes BURST_LEN → pulse `burst_done` next cycle, go IDLE; else go GAP (READ_DELAY>0) or stay READ (READ_DELAY=0).
- GAP: count READ_DELAY cycles, then READ. Gap counter is width $clog2(READ_DELAY+1), minimum 1 bit.
- In-flight flag set on `rinc`; next cycle `rdata` is written into the output buffer and flag cleared.
- Output buffer: 2-entry FIFO; head drives `m_data`/`m_valid`; pop on `m_valid && m_ready`. Simultaneous push and pop allowed; occupancy unchanged.
- `enable` deasserted mid-burst has no effect; burst completes.
- `rempty` high mid-burst: stall in READ indefinitely, no `rinc`; no timeout.
- Never: `rinc` while `rempty`=1; buffer overflow; `rinc` outside READ.

## Timing
- Reset values: `rinc`=0, `m_valid`=0, `m_data`=0, `rd_count`=0, `burst_done`=0, state IDLE, buffer empty, in-flight clear.
- Reset mid-burst: in-flight and buffered words discarded; `m_valid` drops immediately (async).
- `enable` seen in cycle N → first `rinc` earliest N+1.
- `rinc` in cycle N → `rdata` captured at end of N+1 → `m_valid`=1 in N+2 if buffer was empty (latency 2).
- READ_DELAY=D: consecutive `rinc` pulses spaced D+1 cycles when unstalled.
- Back-pressure: `m_ready`=0 holds `m_data` stable; at most 2 words buffered, no further `rinc`.
- `burst_done` in the cycle after the BURST_LEN-th `rinc`; state IDLE that same cycle; `rd_count` holds BURST_LEN until next burst start.

## Structure
- Shared FIFO package: state enum typedef (IDLE, READ, GAP), default DATA_WIDTH/BURST_LEN/READ_DELAY constants.
- Sub-module `out_skid_buf`: 2-entry valid/ready buffer with push, pop, occupancy.
- Top: FSM, gap counter, burst counter, in-flight flag.

## Test plan
- Reset: hold `rrst_n`=0 → all outputs 0; release, `enable`=0 → `rinc` never asserts.
- Nominal burst: FIFO preloaded with 15 words 0x01..0x0F, `m_ready`=1, READ_DELAY=5 → 15 `rinc` pulses 6 cycles apart, `m_data` 0x01..0x0F in order, `burst_done` once.
- Empty stall: 4 words in FIFO → 4 reads, `rinc`=0 while `rempty`; writing word 0x05 resumes read within 1 cycle of `rempty` falling.
- Back-pressure: `m_ready`=0 for 20 cycles → exactly 2 words buffered, `m_data` stable; `m_ready`=1 → remaining words delivered, none lost or duplicated.
- READ_DELAY=0, BURST_LEN=4: `rinc` on 4 consecutive cycles with `m_ready`=1; pop and push in the same cycle keep the stream continuous.
- Reset mid-burst after 7 reads → outputs return to reset values; new `enable` → `rd_count` restarts at 0.
